// File: rtl/cache_tag_ctrl_if.sv
// rtl/cache_tag_ctrl_if.sv - Requester, tag-store and fill-memory signals of the cache tag controller
interface cache_tag_ctrl_if #(
  parameter int bitsDirect = 10,
  parameter int tagBits    = 36,
  parameter int offsetBits = 2
);
  logic                                   req_valid;
  logic                                   req_ready;
  logic [tagBits+bitsDirect+offsetBits-1:0] req_adress;
  logic                                   flush;
  logic                                   resp_valid;
  logic                                   resp_hit;
  logic                                   busy;
  logic                                   tag_we;
  logic                                   tag_re;
  logic [bitsDirect-1:0]                  tag_adress;
  logic [tagBits:0]                       tag_wdata;
  logic [tagBits:0]                       tag_rdata;
  logic                                   mem_req;
  logic [tagBits+bitsDirect-1:0]          mem_adress;
  logic                                   mem_ack;

  // master is the controller side, slave is the requester/tag store/memory side
  modport master (
    input  req_valid, req_adress, flush, tag_rdata, mem_ack,
    output req_ready, resp_valid, resp_hit, busy,
           tag_we, tag_re, tag_adress, tag_wdata, mem_req, mem_adress
  );

  modport slave (
    output req_valid, req_adress, flush, tag_rdata, mem_ack,
    input  req_ready, resp_valid, resp_hit, busy,
           tag_we, tag_re, tag_adress, tag_wdata, mem_req, mem_adress
  );
endinterface

// File: rtl/cache_tag_ctrl.sv
// rtl/cache_tag_ctrl.sv - Direct-mapped cache tag lookup, miss fill and flush sweep controller
module cache_tag_ctrl #(
  parameter int bitsDirect = 10,
  parameter int tagBits    = 36,
  parameter int offsetBits = 2
) (
  input  logic              clk,
  input  logic              gen_reset_n,
  cache_tag_ctrl_if.master  bus
);
  localparam int AW = tagBits + bitsDirect + offsetBits;

  typedef enum logic [2:0] {IDLE, LOOKUP, COMPARE, FILL, UPDATE, FLUSH} state_t;

  state_t                        state;
  logic [tagBits-1:0]            tag_q;
  logic [bitsDirect-1:0]         index_q;
  logic [bitsDirect-1:0]         cnt_q;
  logic                          flush_pend;

  logic                          req_ready_q;
  logic                          busy_q;
  logic                          tag_we_q;
  logic                          tag_re_q;
  logic [bitsDirect-1:0]         tag_adress_q;
  logic [tagBits:0]              tag_wdata_q;
  logic                          mem_req_q;
  logic [tagBits+bitsDirect-1:0] mem_adress_q;
  logic                          upd_resp_q;

  logic [tagBits-1:0]            req_tag;
  logic [bitsDirect-1:0]         req_index;
  logic                          hit;
  logic                          flush_any;
  logic                          accept;

  assign req_tag   = bus.req_adress[AW-1 -: tagBits];
  assign req_index = bus.req_adress[offsetBits +: bitsDirect];
  assign flush_any = bus.flush || flush_pend;
  assign accept    = (state == IDLE) && bus.req_valid && req_ready_q && !bus.flush;

  // tag_rdata only arrives in COMPARE, so the hit response cannot come from a register
  assign hit = (state == COMPARE) && bus.tag_rdata[tagBits] &&
               (bus.tag_rdata[tagBits-1:0] == tag_q);

  assign bus.req_ready  = req_ready_q;
  assign bus.busy       = busy_q;
  assign bus.tag_we     = tag_we_q;
  assign bus.tag_re     = tag_re_q;
  assign bus.tag_adress = tag_adress_q;
  assign bus.tag_wdata  = tag_wdata_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_adress = mem_adress_q;
  assign bus.resp_valid = upd_resp_q || hit;
  assign bus.resp_hit   = hit;

  always_ff @(posedge clk or negedge gen_reset_n) begin
    if (!gen_reset_n) begin
      state        <= IDLE;
      tag_q        <= '0;
      index_q      <= '0;
      cnt_q        <= '0;
      flush_pend   <= 1'b0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      tag_we_q     <= 1'b0;
      tag_re_q     <= 1'b0;
      tag_adress_q <= '0;
      tag_wdata_q  <= '0;
      mem_req_q    <= 1'b0;
      mem_adress_q <= '0;
      upd_resp_q   <= 1'b0;
    end else begin
      // outputs are registered for the state being entered; defaults describe a busy, idle bus
      req_ready_q  <= 1'b0;
      busy_q       <= 1'b1;
      tag_we_q     <= 1'b0;
      tag_re_q     <= 1'b0;
      tag_adress_q <= '0;
      tag_wdata_q  <= '0;
      mem_req_q    <= 1'b0;
      mem_adress_q <= '0;
      upd_resp_q   <= 1'b0;

      if (state != IDLE && bus.flush) begin
        flush_pend <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (flush_any) begin
            state    <= FLUSH;
            cnt_q    <= '0;
            tag_we_q <= 1'b1;
          end else if (accept) begin
            state        <= LOOKUP;
            tag_q        <= req_tag;
            index_q      <= req_index;
            tag_re_q     <= 1'b1;
            tag_adress_q <= req_index;
          end else begin
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        LOOKUP: begin
          state        <= COMPARE;
          tag_re_q     <= 1'b1;
          tag_adress_q <= index_q;
        end
        COMPARE: begin
          if (hit) begin
            if (flush_any) begin
              state    <= FLUSH;
              cnt_q    <= '0;
              tag_we_q <= 1'b1;
            end else begin
              state       <= IDLE;
              req_ready_q <= 1'b1;
              busy_q      <= 1'b0;
            end
          end else begin
            state        <= FILL;
            mem_req_q    <= 1'b1;
            mem_adress_q <= {tag_q, index_q};
          end
        end
        FILL: begin
          if (bus.mem_ack) begin
            state        <= UPDATE;
            tag_we_q     <= 1'b1;
            tag_adress_q <= index_q;
            tag_wdata_q  <= {1'b1, tag_q};
            upd_resp_q   <= 1'b1;
          end else begin
            mem_req_q    <= 1'b1;
            mem_adress_q <= {tag_q, index_q};
          end
        end
        UPDATE: begin
          // a flush that arrived during the miss starts straight after the write
          if (flush_any) begin
            state    <= FLUSH;
            cnt_q    <= '0;
            tag_we_q <= 1'b1;
          end else begin
            state       <= IDLE;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        FLUSH: begin
          if (cnt_q == '1) begin
            state       <= IDLE;
            flush_pend  <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            cnt_q        <= cnt_q + 1'b1;
            tag_we_q     <= 1'b1;
            tag_adress_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cache_tag_ctrl.sv
// tb/tb_cache_tag_ctrl.sv - Directed scoreboard bench for cache_tag_ctrl
module tb_cache_tag_ctrl;
  localparam int BD = 10;
  localparam int TB = 36;
  localparam int OB = 2;

  logic clk = 1'b0;
  logic gen_reset_n;
  logic preload;
  always #5 clk = ~clk;

  cache_tag_ctrl_if #(.bitsDirect(BD), .tagBits(TB), .offsetBits(OB)) bus ();

  cache_tag_ctrl #(.bitsDirect(BD), .tagBits(TB), .offsetBits(OB)) dut (
    .clk         (clk),
    .gen_reset_n (gen_reset_n),
    .bus         (bus)
  );

  int errors = 0;
  int checks = 0;
  bit exp_q[$];
  bit we_re_clash = 1'b0;
  logic [TB:0] store [0:(1<<BD)-1];

  // tag store: one-cycle read latency, preloaded with valid lines so the flush matters
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < (1<<BD); i++) store[i] <= {1'b1, 36'(i*7 + 3)};
    end else begin
      if (bus.tag_re) bus.tag_rdata <= store[bus.tag_adress];
      if (bus.tag_we) store[bus.tag_adress] <= bus.tag_wdata;
    end
  end

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    bit e;
    if (gen_reset_n && bus.resp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", bus.resp_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("sb_resp_hit", bus.resp_hit, e);
      end
    end
    if (bus.tag_we && bus.tag_re) we_re_clash = 1'b1;
  end

  task automatic request(input logic [TB-1:0] tg, input logic [BD-1:0] ix, input bit exp_hit,
                         input int ack_delay, input bit flush_in_fill);
    int n = 0;
    bus.req_adress = {tg, ix, 2'b01};
    bus.req_valid  = 1'b1;
    while (!bus.req_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", n < 2000, 1'b1);
    exp_q.push_back(exp_hit);
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.req_adress = '0;
    check("lookup", {bus.tag_re, bus.tag_we, bus.tag_adress, bus.resp_valid}, {2'b10, ix, 1'b0});
    @(negedge clk);
    check("compare_read", {bus.tag_re, bus.tag_we, bus.tag_adress}, {2'b10, ix});
    check("compare_resp", {bus.resp_valid, bus.resp_hit}, {exp_hit, exp_hit});
    if (!exp_hit) begin
      @(negedge clk);
      check("fill_start", {bus.mem_req, bus.mem_adress, bus.busy}, {1'b1, tg, ix, 1'b1});
      for (int i = 0; i < ack_delay; i++) begin
        bus.flush = flush_in_fill && (i == 1);
        @(negedge clk);
        check("fill_hold", {bus.mem_req, bus.mem_adress, bus.resp_valid}, {1'b1, tg, ix, 1'b0});
      end
      bus.flush   = 1'b0;
      bus.mem_ack = 1'b1;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      check("update", {bus.tag_we, bus.tag_re, bus.mem_req, bus.tag_adress, bus.tag_wdata},
            {3'b100, ix, 1'b1, tg});
      check("update_resp", {bus.resp_valid, bus.resp_hit}, 2'b10);
    end
  endtask

  task automatic after_idle(input string name);
    @(negedge clk);
    check(name, {bus.resp_valid, bus.req_ready, bus.busy, bus.tag_we, bus.tag_re, bus.mem_req},
          6'b010000);
  endtask

  task automatic sweep(input string name);
    int writes = 0;
    int bad = 0;
    int n = 0;
    while (!bus.tag_we && n < 5) begin
      @(negedge clk);
      n++;
    end
    while (bus.tag_we && n < 1200) begin
      if (bus.tag_adress != writes[BD-1:0] || bus.tag_wdata != '0 || bus.req_ready ||
          !bus.busy || bus.tag_re) bad++;
      writes++;
      @(negedge clk);
      n++;
    end
    check({name, "_writes"}, writes, 1024);
    check({name, "_bad"}, bad, 0);
    check({name, "_end"}, {bus.req_ready, bus.busy, bus.tag_we}, 3'b100);
  endtask

  initial begin
    gen_reset_n    = 1'b0;
    preload        = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_adress = '0;
    bus.flush      = 1'b0;
    bus.mem_ack    = 1'b0;
    repeat (2) @(negedge clk);
    preload = 1'b0;
    check("reset_outputs", {bus.req_ready, bus.busy, bus.resp_valid, bus.resp_hit,
                            bus.tag_we, bus.tag_re, bus.mem_req}, 7'b1000000);
    check("reset_buses", {bus.tag_adress, bus.tag_wdata}, '0);
    check("reset_mem_adress", bus.mem_adress, '0);
    @(negedge clk);
    gen_reset_n = 1'b1;
    after_idle("idle_after_reset");

    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    sweep("flush_initial");

    request(36'h123456789, 10'd5, 1'b0, 0, 1'b0);
    after_idle("idle_miss1");
    check("line5_first", store[5], {1'b1, 36'h123456789});
    request(36'h123456789, 10'd5, 1'b1, 0, 1'b0);
    after_idle("idle_hit1");
    request(36'h0000000AB, 10'd5, 1'b0, 2, 1'b0);
    after_idle("idle_mismatch");
    check("line5_ab", store[5], {1'b1, 36'h0000000AB});
    request(36'h123456789, 10'd5, 1'b0, 1, 1'b0);
    after_idle("idle_remiss");

    bus.req_adress = {36'h123456789, 10'd5, 2'b00};
    bus.req_valid  = 1'b1;
    bus.flush      = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_priority", {bus.tag_we, bus.tag_re, bus.req_ready, bus.tag_adress}, {3'b100, 10'd0});
    sweep("flush_vs_req");
    request(36'h123456789, 10'd5, 1'b0, 0, 1'b0);
    after_idle("idle_after_flush_req");

    request(36'h55, 10'd1023, 1'b0, 5, 1'b1);
    @(negedge clk);
    check("flush_after_update", {bus.tag_we, bus.tag_adress, bus.busy, bus.req_ready, bus.resp_valid},
          {1'b1, 10'd0, 3'b100});
    sweep("flush_pending");

    bus.req_adress = {36'h77, 10'd7, 2'b11};
    bus.req_valid  = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("fill_before_reset", {bus.mem_req, bus.mem_adress}, {1'b1, 36'h77, 10'd7});
    #2 gen_reset_n = 1'b0;
    #1 check("reset_in_fill", {bus.mem_req, bus.req_ready, bus.busy, bus.tag_re}, 4'b0100);
    @(negedge clk);
    gen_reset_n = 1'b1;
    after_idle("idle_after_fill_reset");

    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    repeat (100) @(negedge clk);
    check("flush_running", {bus.tag_we, bus.tag_adress}, {1'b1, 10'd100});
    #2 gen_reset_n = 1'b0;
    #1 check("reset_in_flush", {bus.tag_we, bus.busy, bus.req_ready}, 3'b001);
    @(negedge clk);
    gen_reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("no_pending_flush", {bus.tag_we, bus.busy, bus.req_ready}, 3'b001);

    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check("stray_mem_ack", {bus.busy, bus.mem_req, bus.tag_we, bus.req_ready}, 4'b0001);

    request(36'h9, 10'd1023, 1'b0, 0, 1'b0);
    after_idle("idle_last_miss");
    request(36'h9, 10'd1023, 1'b1, 0, 1'b0);
    after_idle("idle_last_hit");

    check("scoreboard_empty", exp_q.size(), 0);
    check("we_re_exclusive", we_re_clash, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
